// File: rtl/character_motion.sv
// character_motion: character position, facing and sprite state driven by
// jump/fall commands and the 1 ms game tick. Successor to the fixed-geometry
// player jump/fall controller, with parametrised geometry, x clamping, a
// one-deep command queue and optional mid-air abort into a fall.
module character_motion #(
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int X_INIT       = 355,
    parameter int Y_INIT       = 454,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 711,
    parameter int DX_STEP      = 1,
    parameter int DY_STEP      = 1,
    parameter int JUMP_HALF_MS = 40,
    parameter int FALL_MS      = 200,
    parameter int QUEUE_EN     = 1,
    parameter int ABORT_EN     = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           module_en,
    input  logic           one_ms_tick,
    input  logic           jump_left,
    input  logic           jump_right,
    input  logic           jump_fail,
    output logic [X_W-1:0] xpos,
    output logic [Y_W-1:0] ypos,
    output logic           mirror,
    output logic           fly,
    output logic           landed,
    output logic           busy,
    output logic           pending
);

    localparam int JUMP_LEN = 2 * JUMP_HALF_MS;
    localparam int T_MAX    = (JUMP_LEN > FALL_MS) ? JUMP_LEN : FALL_MS;
    localparam int TW       = $clog2(T_MAX + 1);
    localparam int Y_TOP    = (1 << Y_W) - 1;

    // Encodings double as command priority: FALL > JUMP_L > JUMP_R > IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        JUMP_R = 2'd1,
        JUMP_L = 2'd2,
        FALL   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    state_t          qstate_q, qstate_d;
    logic            qvalid_q, qvalid_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic            mirror_q, mirror_d;
    logic            fly_q, fly_d;
    logic            landed_q, landed_d;
    logic            busy_q, busy_d;

    logic            soft_rst;
    logic            cmd_valid;
    state_t          cmd_state;

    assign soft_rst = rst || !module_en;

    // Highest-priority command this cycle; jump_fail means nothing while falling.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_state = IDLE;
        if (jump_fail && state_q != FALL) begin
            cmd_valid = 1'b1;
            cmd_state = FALL;
        end else if (jump_left) begin
            cmd_valid = 1'b1;
            cmd_state = JUMP_L;
        end else if (jump_right) begin
            cmd_valid = 1'b1;
            cmd_state = JUMP_R;
        end
    end

    // Next-state, motion and queue logic.
    always_comb begin
        int  xi;
        int  yi;
        logic finish;

        state_d  = state_q;
        qstate_d = qstate_q;
        qvalid_d = qvalid_q;
        timer_d  = timer_q;
        x_d      = x_q;
        y_d      = y_q;
        mirror_d = mirror_q;
        fly_d    = fly_q;
        landed_d = 1'b0;
        finish   = 1'b0;
        xi       = int'(x_q);
        yi       = int'(y_q);

        case (state_q)
            IDLE: begin
                timer_d  = '0;
                fly_d    = 1'b0;
                qvalid_d = 1'b0;
                if (cmd_valid) begin
                    state_d = cmd_state;
                end
            end
            JUMP_R, JUMP_L: begin
                if ((ABORT_EN != 0) && jump_fail) begin
                    state_d  = FALL;
                    timer_d  = '0;
                    qvalid_d = 1'b0;
                end else begin
                    if ((QUEUE_EN != 0) && cmd_valid && (!qvalid_q || cmd_state > qstate_q)) begin
                        qvalid_d = 1'b1;
                        qstate_d = cmd_state;
                    end
                    if (one_ms_tick) begin
                        fly_d = 1'b1;
                        if (state_q == JUMP_L) begin
                            mirror_d = 1'b1;
                            x_d = (xi < X_MIN + DX_STEP) ? X_W'(X_MIN) : X_W'(xi - DX_STEP);
                        end else begin
                            mirror_d = 1'b0;
                            x_d = (xi > X_MAX - DX_STEP) ? X_W'(X_MAX) : X_W'(xi + DX_STEP);
                        end
                        if (int'(timer_q) < JUMP_HALF_MS) begin
                            y_d = Y_W'(yi - DY_STEP);
                        end else begin
                            y_d = Y_W'(yi + DY_STEP);
                        end
                        if (int'(timer_q) == JUMP_LEN - 1) begin
                            finish = 1'b1;
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                end
            end
            FALL: begin
                if ((QUEUE_EN != 0) && cmd_valid && (!qvalid_q || cmd_state > qstate_q)) begin
                    qvalid_d = 1'b1;
                    qstate_d = cmd_state;
                end
                if (one_ms_tick) begin
                    fly_d = 1'b1;
                    y_d   = (yi > Y_TOP - DY_STEP) ? Y_W'(Y_TOP) : Y_W'(yi + DY_STEP);
                    if (int'(timer_q) == FALL_MS - 1) begin
                        finish = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Exit uses the queue as updated this cycle, so a command arriving
        // with the final tick is executed straight away.
        if (finish) begin
            landed_d = 1'b1;
            timer_d  = '0;
            if (qvalid_d) begin
                state_d  = qstate_d;
                qvalid_d = 1'b0;
            end else begin
                state_d = IDLE;
                fly_d   = 1'b0;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state_q  <= IDLE;
            qstate_q <= IDLE;
            qvalid_q <= 1'b0;
            timer_q  <= '0;
            x_q      <= X_W'(X_INIT);
            y_q      <= Y_W'(Y_INIT);
            mirror_q <= 1'b0;
            fly_q    <= 1'b0;
            landed_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            qstate_q <= qstate_d;
            qvalid_q <= qvalid_d;
            timer_q  <= timer_d;
            x_q      <= x_d;
            y_q      <= y_d;
            mirror_q <= mirror_d;
            fly_q    <= fly_d;
            landed_q <= landed_d;
            busy_q   <= busy_d;
        end
    end

    assign xpos    = x_q;
    assign ypos    = y_q;
    assign mirror  = mirror_q;
    assign fly     = fly_q;
    assign landed  = landed_q;
    assign busy    = busy_q;
    assign pending = qvalid_q;

endmodule

// File: tb/tb_character_motion.sv
// Testbench for character_motion: three instances (defaults, X_INIT=5,
// ABORT_EN=0) driven from scenario tasks; expected snapshots are queued
// before each stimulus cycle and popped for comparison after it.
module tb_character_motion;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       m;
        logic       f;
        logic       l;
        logic       b;
        logic       p;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       en   [3];
    logic       jl   [3];
    logic       jr   [3];
    logic       jf   [3];
    logic [9:0] xpos [3];
    logic [9:0] ypos [3];
    logic       mirror [3];
    logic       fly    [3];
    logic       landed [3];
    logic       busy   [3];
    logic       pending[3];

    snap_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    character_motion u_def (
        .clk(clk), .rst(rst), .module_en(en[0]), .one_ms_tick(tick),
        .jump_left(jl[0]), .jump_right(jr[0]), .jump_fail(jf[0]),
        .xpos(xpos[0]), .ypos(ypos[0]), .mirror(mirror[0]), .fly(fly[0]),
        .landed(landed[0]), .busy(busy[0]), .pending(pending[0])
    );

    character_motion #(.X_INIT(5)) u_left (
        .clk(clk), .rst(rst), .module_en(en[1]), .one_ms_tick(tick),
        .jump_left(jl[1]), .jump_right(jr[1]), .jump_fail(jf[1]),
        .xpos(xpos[1]), .ypos(ypos[1]), .mirror(mirror[1]), .fly(fly[1]),
        .landed(landed[1]), .busy(busy[1]), .pending(pending[1])
    );

    character_motion #(.ABORT_EN(0)) u_noab (
        .clk(clk), .rst(rst), .module_en(en[2]), .one_ms_tick(tick),
        .jump_left(jl[2]), .jump_right(jr[2]), .jump_fail(jf[2]),
        .xpos(xpos[2]), .ypos(ypos[2]), .mirror(mirror[2]), .fly(fly[2]),
        .landed(landed[2]), .busy(busy[2]), .pending(pending[2])
    );

    function automatic snap_t snap(input int k);
        snap_t s;
        s.x = xpos[k];
        s.y = ypos[k];
        s.m = mirror[k];
        s.f = fly[k];
        s.l = landed[k];
        s.b = busy[k];
        s.p = pending[k];
        return s;
    endfunction

    function automatic snap_t mk(input int x, input int y, input bit m, input bit f,
                                 input bit l, input bit b, input bit p);
        snap_t s;
        s.x = 10'(x);
        s.y = 10'(y);
        s.m = m;
        s.f = f;
        s.l = l;
        s.b = b;
        s.p = p;
        return s;
    endfunction

    // y after i ticks of a 40+40 jump starting at y0.
    function automatic int jy(input int y0, input int i);
        return y0 - ((i <= 40) ? i : 40) + ((i > 40) ? i - 40 : 0);
    endfunction

    // One clock of stimulus to instance k, sampled at the following negedge.
    task automatic cyc(input int k, input bit t, input bit l, input bit r, input bit f);
        @(negedge clk);
        tick  = t;
        jl[k] = l;
        jr[k] = r;
        jf[k] = f;
        @(negedge clk);
        tick  = 1'b0;
        jl[k] = 1'b0;
        jr[k] = 1'b0;
        jf[k] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        snap_t e, got;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk((k == 1) ? 5 : 355, 454, 0, 0, 0, 0, 0));
        end
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            got = snap(k);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_dut%0d got=%h exp=%h", k, got, e);
            end
        end
        // module_en low behaves as reset, abandoning a started jump.
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        exp_q.push_back(mk(355, 454, 0, 0, 0, 0, 0));
        @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
        en[0] = 1'b1;
        e = exp_q.pop_front();
        got = snap(0);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL module_en_reset got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_jump_right();
        snap_t e, got;
        do_reset();
        exp_q.push_back(mk(355, 454, 0, 0, 0, 1, 0));
        cyc(0, 0, 0, 1, 0);
        e = exp_q.pop_front();
        got = snap(0);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL jr_cmd got=%h exp=%h", got, e);
        end
        for (int i = 1; i <= 80; i++) begin
            exp_q.push_back(mk(355 + i, jy(454, i), 0, i != 80, i == 80, i != 80, 0));
            cyc(0, 1, 0, 0, 0);
            e = exp_q.pop_front();
            got = snap(0);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL jr_tick%0d got=%h exp=%h", i, got, e);
            end
        end
        exp_q.push_back(mk(435, 454, 0, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, 0);
        e = exp_q.pop_front();
        got = snap(0);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL jr_after got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_clamp_left();
        snap_t e, got;
        do_reset();
        exp_q.push_back(mk(5, 454, 0, 0, 0, 1, 0));
        cyc(1, 0, 1, 0, 0);
        e = exp_q.pop_front();
        got = snap(1);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL jl_cmd got=%h exp=%h", got, e);
        end
        for (int i = 1; i <= 80; i++) begin
            exp_q.push_back(mk((i >= 5) ? 0 : 5 - i, jy(454, i), 1, i != 80, i == 80, i != 80, 0));
            cyc(1, 1, 0, 0, 0);
            e = exp_q.pop_front();
            got = snap(1);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL clamp_tick%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_queue();
        snap_t e, got;
        do_reset();
        cyc(0, 0, 0, 1, 0);
        for (int i = 1; i <= 80; i++) begin
            exp_q.push_back(mk(355 + i, jy(454, i), 0, 1, i == 80, 1, (i >= 20) && (i < 80)));
            cyc(0, 1, i == 20, 0, 0);
            e = exp_q.pop_front();
            got = snap(0);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL queue_a_tick%0d got=%h exp=%h", i, got, e);
            end
        end
        for (int i = 1; i <= 80; i++) begin
            exp_q.push_back(mk(435 - i, jy(454, i), 1, i != 80, i == 80, i != 80, 0));
            cyc(0, 1, 0, 0, 0);
            e = exp_q.pop_front();
            got = snap(0);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL queue_b_tick%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_abort();
        snap_t e, got;
        do_reset();
        cyc(0, 0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 1, 0, 0, 0);
        end
        exp_q.push_back(mk(365, 444, 0, 1, 0, 1, 0));
        cyc(0, 0, 0, 0, 1);
        e = exp_q.pop_front();
        got = snap(0);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL abort_enter got=%h exp=%h", got, e);
        end
        for (int i = 1; i <= 200; i++) begin
            exp_q.push_back(mk(365, 444 + i, 0, i != 200, i == 200, i != 200, 0));
            cyc(0, 1, 0, 0, 0);
            e = exp_q.pop_front();
            got = snap(0);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL abort_fall%0d got=%h exp=%h", i, got, e);
            end
        end
        exp_q.push_back(mk(365, 644, 0, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, 0);
        e = exp_q.pop_front();
        got = snap(0);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL abort_after got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_no_abort();
        snap_t e, got;
        do_reset();
        cyc(2, 0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(2, 1, 0, 0, 0);
        end
        exp_q.push_back(mk(365, 444, 0, 1, 0, 1, 1));
        cyc(2, 0, 0, 0, 1);
        e = exp_q.pop_front();
        got = snap(2);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL noab_queue got=%h exp=%h", got, e);
        end
        for (int i = 11; i <= 80; i++) begin
            exp_q.push_back(mk(355 + i, jy(454, i), 0, 1, i == 80, 1, i != 80));
            cyc(2, 1, 0, 0, 0);
            e = exp_q.pop_front();
            got = snap(2);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL noab_tick%0d got=%h exp=%h", i, got, e);
            end
        end
        for (int i = 1; i <= 200; i++) begin
            exp_q.push_back(mk(435, 454 + i, 0, i != 200, i == 200, i != 200, 0));
            cyc(2, 1, 0, 0, 0);
            e = exp_q.pop_front();
            got = snap(2);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL noab_fall%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_fall();
        snap_t e, got;
        do_reset();
        exp_q.push_back(mk(355, 454, 0, 0, 0, 1, 0));
        cyc(0, 0, 0, 0, 1);
        e = exp_q.pop_front();
        got = snap(0);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL fall_cmd got=%h exp=%h", got, e);
        end
        // A jump_fail during the fall is neither acted on nor queued.
        for (int i = 1; i <= 100; i++) begin
            exp_q.push_back(mk(355, 454 + i, 0, 1, 0, 1, 0));
            cyc(0, 1, 0, 0, i == 50);
            e = exp_q.pop_front();
            got = snap(0);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL midfall_tick%0d got=%h exp=%h", i, got, e);
            end
        end
        exp_q.push_back(mk(355, 454, 0, 0, 0, 0, 0));
        do_reset();
        e = exp_q.pop_front();
        got = snap(0);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL midfall_reset got=%h exp=%h", got, e);
        end
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(mk(355, 454, 0, 0, 0, 0, 0));
            cyc(0, 1, 0, 0, 0);
            e = exp_q.pop_front();
            got = snap(0);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL postreset_idle%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b1;
            jl[k] = 1'b0;
            jr[k] = 1'b0;
            jf[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_jump_right();
        test_clamp_left();
        test_queue();
        test_abort();
        test_no_abort();
        test_reset_mid_fall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
